seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Scan controller for the four-digit seven-segment display on its serial shift-register link. Accepts a 13-bit binary value through a valid/ready handshake and converts it to four BCD digits. It builds one 16-bit frame per digit and shifts each frame out serially with a generated shift clock, then latches the frame and holds it for a programmable dwell time. It replaces free-running shifting with a paced, tear-free refresh sequence.

## Interface
- `CLK_DIV`, 4: `i_clk` cycles per half period of `o_segClk`; legal range 1 or greater.
- `DWELL`, 1000: `i_clk` cycles a latched digit is held before the next frame starts; legal range 0 or greater.
- `i_clk` in 1: system clock; all logic is on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_value` in 13: binary value to display, 0..8191.
- `i_valid` in 1: `i_value` is offered.
- `o_ready` out 1: a pending slot is free; a transfer occurs when `i_valid & o_ready`.
- `i_blank` in 1: when high, segment bits of frames are forced to 0; sampled in LOAD.
- `o_segData` out 1: serial frame data, LSB first.
- `o_segClk` out 1: shift clock; the receiver samples on its rising edge.
- `o_segLatch` out 1: active-high latch pulse.
- `o_frameDone` out 1: one-cycle pulse when the digit-3 frame latch completes (one full scan done).

## Operation
- **Frame format.** Frame = {seg[6:0], ctrl[8:0]}, 16 bits, shifted LSB first.
  - seg = {g,f,e,d,c,b,a}, active-high.
  - Digits 0–9 use standard encodings; any other code gives seg 0.
- **Digit control codes (ctrl).**
  - Digit 0 (ones): 9'h040.
  - Digit 1 (tens): 9'h020.
  - Digit 2 (hundreds): 9'h008.
  - Digit 3 (thousands): 9'h004.
- **Registers.**
  - `pend` holds the accepted value; `pend_full` flags it.
  - `disp` holds the value being scanned.
  - `o_ready` = !`pend_full`.
- **Handshake.** When `i_valid & o_ready`, `pend` ← `i_value` and `pend_full` ← 1.
- **States.**
  - IDLE: entered on reset; goes to LOAD in the next cycle with digit 0.
  - LOAD (1 cycle):
    - If digit = 0 and `pend_full`: `disp` ← `pend` and `pend_full` ← 0.
    - Build the frame from `disp`, the digit index and `i_blank` into the shift register.
    - Go to SHIFT.
  - SHIFT (16 bits): per bit, `o_segData` = shift[0] and `o_segClk` = 0 for `CLK_DIV` cycles, then `o_segClk` = 1 for `CLK_DIV` cycles. After the high phase, shift right and increment the bit count. After bit 15, go to LATCH with `o_segClk` = 0 and `o_segData` = 0.
  - LATCH: `o_segLatch` = 1 for 2·`CLK_DIV` cycles. On exit, pulse `o_frameDone` if digit = 3. Go to DWELL.
  - DWELL: count `DWELL` cycles (skip the state if `DWELL` = 0). Then digit ← digit+1 mod 4 and go to LOAD.
- **Value swaps.** A new value reaches the display only at the digit-0 LOAD, so the four digits of one scan always come from one value.
- **Boundary conditions.**
  - `i_valid` while `pend_full`: not accepted, and the held value is unchanged.
  - Multiple offers between scans: only the first is accepted; later offers stall until the next digit-0 LOAD.
  - Digit-0 LOAD and a new `i_valid` in the same cycle: `o_ready` is 0 in that cycle, so there is no acceptance; `o_ready` returns to 1 in the next cycle.
  - Leading zeros are displayed (value 7 → "0007").
  - `i_rst` at any point, including mid-SHIFT: the next cycle is IDLE with all outputs at their reset values, `pend_full` = 0, `disp` = 0 and the digit counter = 0. A partial frame is abandoned without a latch pulse.

## Timing
- **Reset values.**
  - `o_segData` = 0, `o_segClk` = 0, `o_segLatch` = 0, `o_frameDone` = 0.
  - `o_ready` = 1.
- **Latency.**
  - First `o_segClk` rise: 2 + `CLK_DIV` cycles after reset release.
  - Per-digit period: 1 + 32·`CLK_DIV` + 2·`CLK_DIV` + `DWELL` cycles; with the defaults this is 1137 cycles.
  - A full scan is 4 periods.
- **Data stability.** `o_segData` is stable throughout each `o_segClk` high phase and changes only at the start of a low phase.
- **Latch separation.** `o_segLatch` never overlaps `o_segClk` high.
- **Handshake.** `o_ready` is registered; acceptance takes effect in the cycle after the handshake.

## Structure
- `seg_pkg` contains:
  - the frame width constant (16);
  - the four ctrl code constants;
  - the state enum (IDLE, LOAD, SHIFT, LATCH, DWELL);
  - the digit-to-segment encoding function.
- Sub-module `seg_frame_builder`: combinational. Inputs are `disp`, the digit index and blank; output is the 16-bit frame. It performs the binary-to-BCD conversion (double-dabble), the segment encode and the ctrl selection.
- `seg_scan_ctrl` contains the FSM, the bit/phase/dwell counters, the handshake and the shift register.

## Test plan
- **Basic scan.** `CLK_DIV`=1, `DWELL`=4; offer 1234 after reset. Required frames in order:
  - {7'b1100110, 9'h040} ("4")
  - {7'b1001111, 9'h020} ("3")
  - {7'b1011011, 9'h008} ("2")
  - {7'b0000110, 9'h004} ("1")
  - `o_frameDone` pulses once after the fourth latch.
- **Tear-free update.** Offer 1234; during digit-1 SHIFT offer 5678.
  - The current scan completes as 1234.
  - The next scan shows 5678.
  - `o_ready` is low from acceptance until the next digit-0 LOAD.
- **Backpressure.** Offer 10, then 20 and 30 before the next scan.
  - 20 is accepted at the next digit-0 LOAD + 1; 30 is refused while `o_ready` = 0.
  - Scans display 10, 20, 20.
- **Blank.** With `i_blank`=1 and value 9999, every frame has seg = 0 and the ctrl codes are unchanged.
- **Reset mid-frame.** Assert `i_rst` at bit 7 of digit 2.
  - Next cycle: all outputs are at reset values and `o_ready`=1.
  - No latch pulse for the partial frame.
  - The restart is from digit 0 with value 0 ("0000").
- **Timing check.** With the defaults, measure 1137 cycles between consecutive `o_segLatch` rising edges, and confirm data is stable across each `o_segClk` high phase.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, FSM state type and segment encoder for the
// seven-segment scan controller.
//   FRAME_W          serial frame width ({seg[6:0], ctrl[8:0]})
//   CTRL_D0..CTRL_D3 digit select codes carried in the low 9 frame bits
//   state_t          scan FSM states
//   seg_encode()     BCD digit -> {g,f,e,d,c,b,a}, active-high
//   ctrl_code()      digit index -> ctrl code
package seg_pkg;

  localparam int FRAME_W    = 16;
  localparam int SEG_W      = 7;
  localparam int CTRL_W     = 9;
  localparam int VAL_W      = 13;
  localparam int NUM_DIGITS = 4;

  localparam logic [CTRL_W-1:0] CTRL_D0 = 9'h040;  // ones
  localparam logic [CTRL_W-1:0] CTRL_D1 = 9'h020;  // tens
  localparam logic [CTRL_W-1:0] CTRL_D2 = 9'h008;  // hundreds
  localparam logic [CTRL_W-1:0] CTRL_D3 = 9'h004;  // thousands

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DWELL
  } state_t;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  function automatic logic [CTRL_W-1:0] ctrl_code(input logic [1:0] idx);
    logic [CTRL_W-1:0] c;
    case (idx)
      2'd0:    c = CTRL_D0;
      2'd1:    c = CTRL_D1;
      2'd2:    c = CTRL_D2;
      default: c = CTRL_D3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seg_frame_builder.sv
// seg_frame_builder: combinational frame generator.
//   disp   value being scanned (binary, 0..8191)
//   digit  digit index, 0 = ones .. 3 = thousands
//   blank  force segment bits to 0 (ctrl bits are kept)
//   frame  {seg[6:0], ctrl[8:0]}
module seg_frame_builder
  import seg_pkg::*;
(
  input  logic [VAL_W-1:0]   disp,
  input  logic [1:0]         digit,
  input  logic               blank,
  output logic [FRAME_W-1:0] frame
);

  logic [NUM_DIGITS*4-1:0] bcd;
  logic [3:0]              nib;
  logic [SEG_W-1:0]        seg;

  // Double-dabble: before each shift-in, bump any BCD nibble >= 5 by 3 so
  // the following left shift carries correctly into the next decade.
  always_comb begin
    bcd = '0;
    for (int i = VAL_W - 1; i >= 0; i--) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[NUM_DIGITS*4-2:0], disp[i]};
    end
  end

  always_comb begin
    nib   = bcd[digit*4 +: 4];
    seg   = blank ? '0 : seg_encode(nib);
    frame = {seg, ctrl_code(digit)};
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: paced serial refresh of a four-digit seven-segment display.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_value/i_valid     13-bit value offer; accepted when i_valid & o_ready
//   o_ready             pending slot free (registered)
//   i_blank             blank segments of frames built from now on
//   o_segData/o_segClk  serial frame, LSB first, sampled on o_segClk rise
//   o_segLatch          latch pulse, 2*CLK_DIV cycles per frame
//   o_frameDone         one-cycle pulse after the digit-3 latch
// Params: CLK_DIV = i_clk cycles per o_segClk half period (>=1),
//         DWELL   = hold cycles after each latch (>=0).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DWELL   = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [VAL_W-1:0] i_value,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_blank,
  output logic             o_segData,
  output logic             o_segClk,
  output logic             o_segLatch,
  output logic             o_frameDone
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LT_W = $clog2(2 * CLK_DIV);
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [LT_W-1:0] LT_LAST = LT_W'(2 * CLK_DIV - 1);
  localparam logic [DW_W-1:0] DW_LAST = (DWELL > 0) ? DW_W'(DWELL - 1) : '0;

  state_t             state, state_nxt;
  logic [1:0]         digit;
  logic [3:0]         bit_cnt;
  logic [PH_W-1:0]    ph_cnt;
  logic               hi;        // current o_segClk phase within SHIFT
  logic [LT_W-1:0]    lt_cnt;
  logic [DW_W-1:0]    dw_cnt;
  logic [FRAME_W-1:0] shreg;
  logic [VAL_W-1:0]   pend, disp;
  logic               pend_full;
  logic               frame_done;

  logic               ph_end, lt_end, dw_end, swap;
  logic [VAL_W-1:0]   load_val;
  logic [FRAME_W-1:0] frame;

  assign ph_end = (ph_cnt == PH_LAST);
  assign lt_end = (lt_cnt == LT_LAST);
  assign dw_end = (dw_cnt == DW_LAST);

  // Value swap only at the digit-0 load keeps a scan's four digits coherent.
  // The frame must be built from the incoming value in that same cycle.
  assign swap     = (state == ST_LOAD) && (digit == 2'd0) && pend_full;
  assign load_val = swap ? pend : disp;

  seg_frame_builder u_frame (
    .disp  (load_val),
    .digit (digit),
    .blank (i_blank),
    .frame (frame)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_segData  = 1'b0;
    o_segClk   = 1'b0;
    o_segLatch = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        o_segData = shreg[0];
        o_segClk  = hi;
        if (hi && ph_end && bit_cnt == 4'd15) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        o_segLatch = 1'b1;
        if (lt_end) state_nxt = (DWELL == 0) ? ST_LOAD : ST_DWELL;
      end
      ST_DWELL: if (dw_end) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      digit      <= '0;
      bit_cnt    <= '0;
      ph_cnt     <= '0;
      hi         <= 1'b0;
      lt_cnt     <= '0;
      dw_cnt     <= '0;
      shreg      <= '0;
      pend       <= '0;
      disp       <= '0;
      pend_full  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (i_valid && !pend_full) begin
        pend      <= i_value;
        pend_full <= 1'b1;
      end
      if (swap) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end

      case (state)
        ST_LOAD: begin
          shreg   <= frame;
          bit_cnt <= '0;
          ph_cnt  <= '0;
          hi      <= 1'b0;
          lt_cnt  <= '0;
          dw_cnt  <= '0;
        end
        ST_SHIFT: begin
          if (ph_end) begin
            ph_cnt <= '0;
            // Data advances only at the high->low transition so it is
            // stable for the receiver's rising-edge sample.
            if (hi) begin
              hi      <= 1'b0;
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end else begin
              hi <= 1'b1;
            end
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        ST_LATCH: begin
          if (lt_end) begin
            lt_cnt     <= '0;
            dw_cnt     <= '0;
            frame_done <= (digit == 2'd3);
            if (DWELL == 0) digit <= digit + 2'd1;
          end else begin
            lt_cnt <= lt_cnt + LT_W'(1);
          end
        end
        ST_DWELL: begin
          if (dw_end) begin
            dw_cnt <= '0;
            digit  <= digit + 2'd1;
          end else begin
            dw_cnt <= dw_cnt + DW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = !pend_full;
  assign o_frameDone = frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Fast instance: CLK_DIV=1, DWELL=4
  logic        rst = 1'b1, valid = 1'b0, blank = 1'b0;
  logic [12:0] value = '0;
  logic        ready, sdata, sclk, slatch, fdone;

  seg_scan_ctrl #(.CLK_DIV(1), .DWELL(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_valid(valid),
    .o_ready(ready), .i_blank(blank), .o_segData(sdata), .o_segClk(sclk),
    .o_segLatch(slatch), .o_frameDone(fdone)
  );

  // Default-parameter instance for the timing check
  logic        rst_d = 1'b1;
  logic        d_ready, d_sdata, d_sclk, d_slatch, d_fdone;
  logic [12:0] d_value = '0;
  logic        d_valid = 1'b0, d_blank = 1'b0;

  seg_scan_ctrl dut_def (
    .i_clk(clk), .i_rst(rst_d), .i_value(d_value), .i_valid(d_valid),
    .o_ready(d_ready), .i_blank(d_blank), .o_segData(d_sdata), .o_segClk(d_sclk),
    .o_segLatch(d_slatch), .o_frameDone(d_fdone)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_t [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                              7'b1111111, 7'b1101111};
  logic [8:0] ctrl_t [0:3] = '{9'h040, 9'h020, 9'h008, 9'h004};

  // Receiver model for the fast instance
  logic        p_clk = 0, p_latch = 0, p_data = 0;
  logic [15:0] acc = '0;
  int          nbits = 0, fd_cnt = 0, stab_err = 0, ovl_err = 0;
  logic [15:0] frames [$];

  always @(negedge clk) begin
    if (rst) begin
      nbits = 0;
      acc   = '0;
    end else begin
      if (sclk && !p_clk) begin acc = {sdata, acc[15:1]}; nbits++; end
      if (sclk && p_clk && sdata !== p_data) stab_err++;
      if (slatch && sclk) ovl_err++;
      if (slatch && !p_latch) begin frames.push_back(acc); nbits = 0; end
      if (fdone) fd_cnt++;
    end
    p_clk = sclk; p_latch = slatch; p_data = sdata;
  end

  // Monitor for the default instance
  logic dp_clk = 0, dp_latch = 0, dp_data = 0;
  int   d_rise [$];
  int   rel_cyc = 0, d_first_rise = -1, d_stab_err = 0, d_ovl_err = 0;

  always @(negedge clk) begin
    if (!rst_d) begin
      if (d_sclk && !dp_clk && d_first_rise < 0) d_first_rise = cyc - rel_cyc;
      if (d_sclk && dp_clk && d_sdata !== dp_data) d_stab_err++;
      if (d_slatch && d_sclk) d_ovl_err++;
      if (d_slatch && !dp_latch) d_rise.push_back(cyc);
    end
    dp_clk = d_sclk; dp_latch = d_slatch; dp_data = d_sdata;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; blank = 1'b0;
    repeat (3) step();
    frames.delete();
    fd_cnt = 0; stab_err = 0; ovl_err = 0;
    rst = 1'b0;
  endtask

  task automatic offer(input logic [12:0] v, input int budget, output bit ok);
    ok = 1'b0; value = v; valid = 1'b1;
    for (int n = 0; n < budget; n++) begin
      if (ready) begin
        @(posedge clk);
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames.size() < n && k < budget) begin step(); k++; end
    if (frames.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_frames: got %0d frames, need %0d", frames.size(), n);
    end
  endtask

  task automatic check_scan(input string name, input int base,
                            input int d0, input int d1, input int d2, input int d3);
    int          dg [4];
    logic [15:0] exp_f;
    dg = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      exp_f = {seg_t[dg[i]], ctrl_t[i]};
      n_checks++;
      if (base + i >= frames.size()) begin
        n_fail++;
        $display("FAIL %s digit %0d: frame missing, want %h", name, i, exp_f);
      end else if (frames[base+i] !== exp_f) begin
        n_fail++;
        $display("FAIL %s digit %0d: got %h want %h", name, i, frames[base+i], exp_f);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0;
    repeat (2) step();
    n_checks += 5;
    if (sdata  !== 1'b0) begin n_fail++; $display("FAIL rst_sdata: got %b want 0", sdata); end
    if (sclk   !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b want 0", sclk); end
    if (slatch !== 1'b0) begin n_fail++; $display("FAIL rst_latch: got %b want 0", slatch); end
    if (fdone  !== 1'b0) begin n_fail++; $display("FAIL rst_fdone: got %b want 0", fdone); end
    if (ready  !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready); end
  endtask

  task automatic test_basic_scan();
    bit ok;
    do_reset();
    offer(13'd1234, 5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_accept: got 0 want 1"); end
    wait_frames(3, 400);
    n_checks++;
    if (fd_cnt !== 0) begin n_fail++; $display("FAIL basic_fd_early: got %0d want 0", fd_cnt); end
    wait_frames(4, 200);
    repeat (5) step();
    n_checks++;
    if (fd_cnt !== 1) begin n_fail++; $display("FAIL basic_fd: got %0d want 1", fd_cnt); end
    check_scan("basic", 0, 4, 3, 2, 1);
    n_checks += 2;
    if (stab_err !== 0) begin n_fail++; $display("FAIL basic_stable: got %0d want 0", stab_err); end
    if (ovl_err  !== 0) begin n_fail++; $display("FAIL basic_overlap: got %0d want 0", ovl_err); end
  endtask

  task automatic test_tear_free();
    bit ok;
    int k;
    do_reset();
    offer(13'd1234, 5, ok);
    k = 0;
    while (!(frames.size() >= 1 && nbits >= 1) && k < 400) begin step(); k++; end
    offer(13'd5678, 10, ok);
    n_checks += 2;
    if (!ok) begin n_fail++; $display("FAIL tear_accept: got 0 want 1"); end
    if (ready !== 1'b0) begin n_fail++; $display("FAIL tear_ready_low: got %b want 0", ready); end
    wait_frames(4, 400);
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL tear_ready_hold: got %b want 0", ready); end
    wait_frames(5, 200);
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL tear_ready_back: got %b want 1", ready); end
    wait_frames(8, 400);
    check_scan("tear_scan1", 0, 4, 3, 2, 1);
    check_scan("tear_scan2", 4, 8, 7, 6, 5);
  endtask

  task automatic test_backpressure();
    bit ok;
    int k;
    do_reset();
    k = 0;
    while (nbits < 1 && k < 50) begin step(); k++; end
    offer(13'd10, 5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_accept10: got 0 want 1"); end
    offer(13'd20, 400, ok);
    n_checks += 2;
    if (!ok) begin n_fail++; $display("FAIL bp_accept20: got 0 want 1"); end
    if (frames.size() !== 4) begin
      n_fail++; $display("FAIL bp_accept20_when: got %0d frames want 4", frames.size());
    end
    offer(13'd30, 100, ok);
    n_checks++;
    if (ok) begin n_fail++; $display("FAIL bp_refuse30: got 1 want 0"); end
    wait_frames(16, 800);
    check_scan("bp_scan1", 0, 0, 0, 0, 0);
    check_scan("bp_scan2", 4, 0, 1, 0, 0);
    check_scan("bp_scan3", 8, 0, 2, 0, 0);
    check_scan("bp_scan4", 12, 0, 2, 0, 0);
  endtask

  task automatic test_blank();
    bit ok;
    do_reset();
    blank = 1'b1;
    offer(13'd9999, 5, ok);
    wait_frames(4, 400);
    blank = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= frames.size() || frames[i] !== {7'b0, ctrl_t[i]}) begin
        n_fail++;
        $display("FAIL blank digit %0d: got %h want %h", i,
                 (i < frames.size()) ? frames[i] : 16'hxxxx, {7'b0, ctrl_t[i]});
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k, nf;
    do_reset();
    offer(13'd1234, 5, ok);
    k = 0;
    while (!(frames.size() >= 2 && nbits >= 7) && k < 400) begin step(); k++; end
    rst = 1'b1;
    step();
    n_checks += 5;
    if (sdata  !== 1'b0) begin n_fail++; $display("FAIL mid_sdata: got %b want 0", sdata); end
    if (sclk   !== 1'b0) begin n_fail++; $display("FAIL mid_sclk: got %b want 0", sclk); end
    if (slatch !== 1'b0) begin n_fail++; $display("FAIL mid_latch: got %b want 0", slatch); end
    if (fdone  !== 1'b0) begin n_fail++; $display("FAIL mid_fdone: got %b want 0", fdone); end
    if (ready  !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", ready); end
    nf = frames.size();
    n_checks++;
    if (nf !== 2) begin n_fail++; $display("FAIL mid_partial_latch: got %0d frames want 2", nf); end
    step();
    rst = 1'b0;
    wait_frames(nf + 4, 400);
    check_scan("mid_restart", nf, 0, 0, 0, 0);
  endtask

  task automatic test_timing();
    int k;
    rst_d = 1'b1;
    repeat (2) step();
    d_rise.delete();
    d_first_rise = -1; d_stab_err = 0; d_ovl_err = 0;
    rst_d   = 1'b0;
    rel_cyc = cyc;
    k = 0;
    while (d_rise.size() < 3 && k < 5000) begin step(); k++; end
    n_checks += 5;
    if (d_first_rise !== 6) begin
      n_fail++; $display("FAIL tim_first_rise: got %0d want 6", d_first_rise);
    end
    if (d_rise.size() < 3) begin
      n_fail += 2; $display("FAIL tim_period: got %0d latch edges want 3", d_rise.size());
    end else begin
      if (d_rise[1] - d_rise[0] !== 1137) begin
        n_fail++; $display("FAIL tim_period1: got %0d want 1137", d_rise[1] - d_rise[0]);
      end
      if (d_rise[2] - d_rise[1] !== 1137) begin
        n_fail++; $display("FAIL tim_period2: got %0d want 1137", d_rise[2] - d_rise[1]);
      end
    end
    if (d_stab_err !== 0) begin n_fail++; $display("FAIL tim_stable: got %0d want 0", d_stab_err); end
    if (d_ovl_err  !== 0) begin n_fail++; $display("FAIL tim_overlap: got %0d want 0", d_ovl_err); end
  endtask

  initial begin
    step();
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_backpressure();
    test_blank();
    test_reset_mid();
    test_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
